instruction_encoder: RTL and testbench



---
 rtl/armaria_isa_pkg.sv | 49 ++++
 rtl/instruction_field_packer.sv | 127 ++++++++++++
 rtl/instruction_encoder.sv | 143 ++++++++++++++
 tb/tb_instruction_encoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armaria_isa_pkg.sv
// Shared ARMAria ISA definitions: field widths, instruction IDs, major opcodes,
// architectural register indices and the loader FSM state type.
package armaria_isa_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned ID_W     = 7;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned OFFSET_W = 12;
    localparam int unsigned COND_W   = 4;

    localparam logic [ID_W-1:0] ID_LSL    = 7'h01;
    localparam logic [ID_W-1:0] ID_LSR    = 7'h02;
    localparam logic [ID_W-1:0] ID_ADD3   = 7'h03;
    localparam logic [ID_W-1:0] ID_MOVI   = 7'h08;
    localparam logic [ID_W-1:0] ID_ALU_LO = 7'h0c;
    localparam logic [ID_W-1:0] ID_CMPC   = 7'h26;
    localparam logic [ID_W-1:0] ID_LDPC   = 7'h27;
    localparam logic [ID_W-1:0] ID_MEMR   = 7'h28;
    localparam logic [ID_W-1:0] ID_MEMI   = 7'h30;
    localparam logic [ID_W-1:0] ID_JMP    = 7'h48;
    localparam logic [ID_W-1:0] ID_BRC    = 7'h49;
    localparam logic [ID_W-1:0] ID_NOP    = 7'h4a;
    localparam logic [ID_W-1:0] ID_HLT    = 7'h4b;
    localparam logic [ID_W-1:0] ID_RESET  = 7'h64;

    localparam logic [3:0] OPC_SHIFT  = 4'h0;
    localparam logic [3:0] OPC_ADDSUB = 4'h1;
    localparam logic [2:0] OPC_MOVI   = 3'b001;
    localparam logic [3:0] OPC_ALU    = 4'h4;
    localparam logic [3:0] OPC_MEMR   = 4'h5;
    localparam logic [3:0] OPC_MEMI   = 4'h6;
    localparam logic [3:0] OPC_SPREL  = 4'h9;
    localparam logic [3:0] OPC_ADDR   = 4'ha;
    localparam logic [3:0] OPC_MISC   = 4'hb;
    localparam logic [3:0] OPC_JMP    = 4'hc;
    localparam logic [3:0] OPC_BRC    = 4'hd;
    localparam logic [3:0] OPC_SYS    = 4'he;

    localparam logic [REG_W-1:0] LINK = 4'hc;
    localparam logic [REG_W-1:0] SP   = 4'he;
    localparam logic [REG_W-1:0] PC   = 4'hf;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } encoder_state_e;

endpackage

// File: rtl/instruction_field_packer.sv
// Combinational packer: decoded instruction fields to a 16-bit ARMAria word,
// flagging IDs that have no encoding.
module instruction_field_packer
    import armaria_isa_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH      = 16,
    parameter int unsigned ID_WIDTH               = 7,
    parameter int unsigned REGISTER_WIDTH         = 4,
    parameter int unsigned OFFSET_WIDTH           = 12,
    parameter int unsigned BRANCH_CONDITION_WIDTH = 4
) (
    input  logic [ID_WIDTH-1:0]               id,
    input  logic [REGISTER_WIDTH-1:0]         reg_d,
    input  logic [REGISTER_WIDTH-1:0]         reg_a,
    input  logic [REGISTER_WIDTH-1:0]         reg_b,
    input  logic [OFFSET_WIDTH-1:0]           offset,
    input  logic [BRANCH_CONDITION_WIDTH-1:0] cond,
    output logic [INSTRUCTION_WIDTH-1:0]      word,
    output logic                              invalid
);

    logic [6:0] k;
    logic [2:0] f2;
    logic [1:0] f1;
    logic [3:0] opc;

    // Upper offset bits never reach any encoding.
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[OFFSET_WIDTH-1:8];

    always_comb begin
        word    = '0;
        invalid = 1'b0;
        k       = '0;
        f2      = '0;
        f1      = '0;
        opc     = '0;
        case (id) inside
            ID_LSL, ID_LSR:
                word = {OPC_SHIFT, id == ID_LSR, offset[4:0], reg_a[2:0], reg_d[2:0]};
            ID_ADD3:
                word = {OPC_ADDSUB, 1'b0, offset[4:0], reg_a[2:0], reg_d[2:0]};
            [7'h04:7'h07]: begin
                k    = id - 7'h04;
                word = {OPC_ADDSUB, 1'b1, k[1:0],
                        (id < 7'h06) ? reg_b[2:0] : offset[2:0], reg_a[2:0], reg_d[2:0]};
            end
            [7'h08:7'h0b]:
                word = {OPC_MOVI, id[1], id[0], reg_d[2:0], offset[7:0]};
            [7'h0c:7'h1b]: begin
                k    = id - ID_ALU_LO;
                word = {OPC_ALU, 1'b0, 1'b0, k[3:2], k[1:0], reg_b[2:0], reg_d[2:0]};
            end
            [7'h1c:7'h21]: begin
                // Six IDs spread as three sub-ops each over f2 = 4 and 5, f1 = 1..3.
                k = id - 7'h1c;
                if (k < 7'd3) begin
                    f2 = 3'd4;
                    f1 = k[1:0] + 2'd1;
                end else begin
                    f2 = 3'd5;
                    f1 = k[1:0] - 2'd2;
                end
                word = {OPC_ALU, 1'b0, f2, f1, reg_b[2:0], reg_d[2:0]};
            end
            [7'h22:7'h25]: begin
                k    = id - 7'h22;
                word = {OPC_ALU, 1'b0, 3'd6, k[1:0], reg_b[2:0], reg_d[2:0]};
            end
            ID_CMPC:
                word = {OPC_ALU, 4'b0111, cond[3:0], 1'b0, reg_b[2:0]};
            ID_LDPC:
                word = {OPC_ALU, 1'b1, reg_d[2:0], offset[7:0]};
            [7'h28:7'h2f]: begin
                k    = id - ID_MEMR;
                word = {OPC_MEMR, k[2:0], reg_b[2:0], reg_a[2:0], reg_d[2:0]};
            end
            [7'h30:7'h35]: begin
                k    = id - ID_MEMI;
                opc  = OPC_MEMI + {2'b00, k[2:1]};
                word = {opc, id[0], offset[4:0], reg_a[2:0], reg_d[2:0]};
            end
            7'h36, 7'h37:
                word = {OPC_SPREL, id[0], reg_d[2:0], offset[7:0]};
            7'h38, 7'h39:
                word = {OPC_ADDR, id[0], reg_d[2:0], offset[7:0]};
            7'h3a:
                word = {OPC_MISC, 4'b0000, 2'b00, 2'b00, reg_d[3:0]};
            7'h4c:
                word = {OPC_MISC, 4'b0000, 2'b01, 2'b00, reg_a[3:0]};
            7'h4f, 7'h50:
                word = {OPC_MISC, 4'b0001, id == 7'h50, 3'b000, reg_b[3:0]};
            [7'h3b:7'h3e]: begin
                k    = id - 7'h3b;
                word = {OPC_MISC, 4'b0010, k[1:0], reg_b[2:0], reg_d[2:0]};
            end
            [7'h3f:7'h42]: begin
                k    = id - 7'h3f;
                word = {OPC_MISC, 4'b1010, k[1:0], reg_b[2:0], reg_d[2:0]};
            end
            7'h43:
                word = {OPC_MISC, 4'b0100, 1'b0, 4'b0000, reg_d[2:0]};
            7'h44:
                word = {OPC_MISC, 4'b1101, 1'b0, 4'b0000, reg_d[2:0]};
            7'h4d:
                word = {OPC_MISC, 4'b0100, 1'b1, offset[6:0]};
            7'h4e:
                word = {OPC_MISC, 4'b1101, 1'b1, offset[6:0]};
            [7'h45:7'h47]: begin
                k    = id - 7'h45;
                word = {OPC_MISC, 4'b1110, k[1:0], 3'b000,
                        (id == 7'h46) ? 3'b000 : reg_d[2:0]};
            end
            ID_JMP:
                word = {OPC_JMP, 4'b0000, offset[7:0]};
            ID_BRC:
                word = {OPC_BRC, cond[3:0], offset[7:0]};
            ID_NOP, ID_HLT:
                word = {OPC_SYS, id[0], 11'b0};
            ID_RESET:
                word = '1;
            default:
                invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Field-level program loader: packs accepted instruction fields and streams them
// into instruction memory, one word per accepted transfer, until an HLT is written.
module instruction_encoder
    import armaria_isa_pkg::*;
#(
    parameter int unsigned INSTRUCTION_WIDTH      = 16,
    parameter int unsigned ID_WIDTH               = 7,
    parameter int unsigned REGISTER_WIDTH         = 4,
    parameter int unsigned OFFSET_WIDTH           = 12,
    parameter int unsigned BRANCH_CONDITION_WIDTH = 4,
    parameter int unsigned ADDRESS_WIDTH          = 12
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDRESS_WIDTH-1:0]          start_address,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ID_WIDTH-1:0]               ID,
    input  logic [REGISTER_WIDTH-1:0]         RegD,
    input  logic [REGISTER_WIDTH-1:0]         RegA,
    input  logic [REGISTER_WIDTH-1:0]         RegB,
    input  logic [OFFSET_WIDTH-1:0]           Offset,
    input  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition,
    output logic                              mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0]          mem_address,
    output logic [INSTRUCTION_WIDTH-1:0]      mem_data,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [ID_WIDTH-1:0]               error_id,
    output logic [ADDRESS_WIDTH:0]            word_count
);

    encoder_state_e state_q, state_d;

    logic                         transfer;
    logic                         accept_write;
    logic                         packed_invalid;
    logic [INSTRUCTION_WIDTH-1:0] packed_word;

    logic                         write_q;
    logic [INSTRUCTION_WIDTH-1:0] data_q;
    logic [ADDRESS_WIDTH-1:0]     address_q;
    logic [ADDRESS_WIDTH:0]       count_q;
    logic                         error_q;
    logic [ID_WIDTH-1:0]          error_id_q;

    instruction_field_packer #(
        .INSTRUCTION_WIDTH      (INSTRUCTION_WIDTH),
        .ID_WIDTH               (ID_WIDTH),
        .REGISTER_WIDTH         (REGISTER_WIDTH),
        .OFFSET_WIDTH           (OFFSET_WIDTH),
        .BRANCH_CONDITION_WIDTH (BRANCH_CONDITION_WIDTH)
    ) u_packer (
        .id      (ID),
        .reg_d   (RegD),
        .reg_a   (RegA),
        .reg_b   (RegB),
        .offset  (Offset),
        .cond    (branch_condition),
        .word    (packed_word),
        .invalid (packed_invalid)
    );

    assign transfer     = in_valid && in_ready;
    assign accept_write = transfer && !packed_invalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: begin
                if (start) begin
                    state_d = StLoad;
                end else if (accept_write && ID == ID_HLT) begin
                    state_d = StDone;
                end
            end
            StDone: if (start) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StLoad);
        done     = (state_q == StDone);
        in_ready = (state_q == StLoad) && !start;
    end

    // start never coincides with a transfer, so session clears need no priority over captures.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q    <= 1'b0;
            data_q     <= '0;
            address_q  <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            error_id_q <= '0;
        end else begin
            write_q <= accept_write;
            if (accept_write) begin
                data_q <= packed_word;
            end
            if (start) begin
                address_q  <= start_address;
                count_q    <= '0;
                error_q    <= 1'b0;
                error_id_q <= '0;
            end else begin
                if (write_q) begin
                    address_q <= address_q + 1'b1;
                end
                if (accept_write && count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
                if (transfer && packed_invalid) begin
                    error_q <= 1'b1;
                    if (!error_q) begin
                        error_id_q <= ID;
                    end
                end
            end
        end
    end

    // Gating with reset kills a strobe that would otherwise land in the reset cycle.
    assign mem_write_enable = write_q && !reset;
    assign mem_address      = address_q;
    assign mem_data         = data_q;
    assign error            = error_q;
    assign error_id         = error_id_q;
    assign word_count       = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus randomized field sets
// checked against an arithmetic reference encoding and a session model.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] start_address;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  ID;
    logic [3:0]  RegD, RegA, RegB;
    logic [11:0] Offset;
    logic [3:0]  branch_condition;
    logic        mem_write_enable;
    logic [11:0] mem_address;
    logic [15:0] mem_data;
    logic        busy, done, error;
    logic [6:0]  error_id;
    logic [12:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_addr;
    logic [12:0] exp_count;
    logic        exp_error;
    logic [6:0]  exp_eid;
    logic        exp_busy, exp_done;

    always #5 clock = ~clock;

    instruction_encoder dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .start_address    (start_address),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .ID               (ID),
        .RegD             (RegD),
        .RegA             (RegA),
        .RegB             (RegB),
        .Offset           (Offset),
        .branch_condition (branch_condition),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .error_id         (error_id),
        .word_count       (word_count)
    );

    task automatic check(input string tag, input bit ok, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from shifted integer fields; bit 16 is "encodable".
    function automatic logic [16:0] ref_encode(input int id, input int d, input int a,
                                               input int b, input int off, input int cond);
        int w;
        int k;
        int ok;
        ok = 1;
        w  = 0;
        if (id == 1 || id == 2)
            w = ((id == 2 ? 1 : 0) << 11) | ((off & 31) << 6) | ((a & 7) << 3) | (d & 7);
        else if (id == 3)
            w = (1 << 12) | ((off & 31) << 6) | ((a & 7) << 3) | (d & 7);
        else if (id >= 4 && id <= 7)
            w = (1 << 12) | (1 << 11) | ((id - 4) << 9) | ((id < 6 ? (b & 7) : (off & 7)) << 6)
                | ((a & 7) << 3) | (d & 7);
        else if (id >= 8 && id <= 11)
            w = (1 << 13) | ((id & 3) << 11) | ((d & 7) << 8) | (off & 255);
        else if (id >= 'h0c && id <= 'h1b) begin
            k = id - 'h0c;
            w = (4 << 12) | ((k / 4) << 8) | ((k % 4) << 6) | ((b & 7) << 3) | (d & 7);
        end else if (id >= 'h1c && id <= 'h21) begin
            k = id - 'h1c;
            w = (4 << 12) | ((4 + k / 3) << 8) | ((1 + k % 3) << 6) | ((b & 7) << 3) | (d & 7);
        end else if (id >= 'h22 && id <= 'h25)
            w = (4 << 12) | (6 << 8) | ((id - 'h22) << 6) | ((b & 7) << 3) | (d & 7);
        else if (id == 'h26)
            w = (4 << 12) | (7 << 8) | ((cond & 15) << 4) | (b & 7);
        else if (id == 'h27)
            w = (4 << 12) | (1 << 11) | ((d & 7) << 8) | (off & 255);
        else if (id >= 'h28 && id <= 'h2f)
            w = (5 << 12) | ((id - 'h28) << 9) | ((b & 7) << 6) | ((a & 7) << 3) | (d & 7);
        else if (id >= 'h30 && id <= 'h35)
            w = ((6 + (id - 'h30) / 2) << 12) | ((id & 1) << 11) | ((off & 31) << 6)
                | ((a & 7) << 3) | (d & 7);
        else if (id >= 'h36 && id <= 'h39)
            w = ((id < 'h38 ? 9 : 10) << 12) | ((id & 1) << 11) | ((d & 7) << 8) | (off & 255);
        else if (id == 'h3a)
            w = (11 << 12) | (d & 15);
        else if (id == 'h4c)
            w = (11 << 12) | (1 << 6) | (a & 15);
        else if (id == 'h4f || id == 'h50)
            w = (11 << 12) | (1 << 8) | ((id == 'h50 ? 1 : 0) << 7) | (b & 15);
        else if (id >= 'h3b && id <= 'h3e)
            w = (11 << 12) | (2 << 8) | ((id - 'h3b) << 6) | ((b & 7) << 3) | (d & 7);
        else if (id >= 'h3f && id <= 'h42)
            w = (11 << 12) | (10 << 8) | ((id - 'h3f) << 6) | ((b & 7) << 3) | (d & 7);
        else if (id == 'h43 || id == 'h44)
            w = (11 << 12) | ((id == 'h43 ? 4 : 13) << 8) | (d & 7);
        else if (id == 'h4d || id == 'h4e)
            w = (11 << 12) | ((id == 'h4d ? 4 : 13) << 8) | (1 << 7) | (off & 127);
        else if (id >= 'h45 && id <= 'h47)
            w = (11 << 12) | (14 << 8) | ((id - 'h45) << 6) | (id == 'h46 ? 0 : (d & 7));
        else if (id == 'h48)
            w = (12 << 12) | (off & 255);
        else if (id == 'h49)
            w = (13 << 12) | ((cond & 15) << 8) | (off & 255);
        else if (id == 'h4a || id == 'h4b)
            w = (14 << 12) | ((id & 1) << 11);
        else if (id == 'h64)
            w = 'hffff;
        else
            ok = 0;
        return {ok[0], w[15:0]};
    endfunction

    task automatic check_status();
        check("word_count", word_count === exp_count, word_count, exp_count);
        check("error", error === exp_error, error, exp_error);
        check("error_id", error_id === exp_eid, error_id, exp_eid);
        check("busy", busy === exp_busy, busy, exp_busy);
        check("done", done === exp_done, done, exp_done);
    endtask

    // One transfer; returns at the falling edge of the cycle carrying its write.
    task automatic send(input int id, input int d, input int a, input int b,
                        input int off, input int cond);
        logic [16:0] r;
        in_valid = 1'b1;
        ID = id[6:0]; RegD = d[3:0]; RegA = a[3:0]; RegB = b[3:0];
        Offset = off[11:0]; branch_condition = cond[3:0];
        #1;
        check("in_ready", in_ready === 1'b1, in_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        r = ref_encode(id, d, a, b, off, cond);
        if (r[16]) begin
            check("write_strobe", mem_write_enable === 1'b1, mem_write_enable, 1'b1);
            check("write_addr", mem_address === exp_addr, mem_address, exp_addr);
            check("write_data", mem_data === r[15:0], mem_data, r[15:0]);
            exp_addr = exp_addr + 12'd1;
            if (exp_count != '1) exp_count = exp_count + 13'd1;
            if (id == 'h4b) begin
                exp_done = 1'b1;
                exp_busy = 1'b0;
            end
        end else begin
            check("no_write_invalid", mem_write_enable === 1'b0, mem_write_enable, 1'b0);
            if (!exp_error) exp_eid = id[6:0];
            exp_error = 1'b1;
        end
        check_status();
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        check("idle_no_write", mem_write_enable === 1'b0, mem_write_enable, 1'b0);
        check("idle_addr", mem_address === exp_addr, mem_address, exp_addr);
    endtask

    task automatic do_start(input logic [11:0] addr);
        start = 1'b1;
        start_address = addr;
        #1;
        check("ready_low_on_start", in_ready === 1'b0, in_ready, 1'b0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        exp_addr = addr; exp_count = '0; exp_error = 1'b0; exp_eid = '0;
        exp_busy = 1'b1; exp_done = 1'b0;
        check("start_addr", mem_address === exp_addr, mem_address, exp_addr);
        check_status();
    endtask

    task automatic check_all_zero();
        check("rst_we", mem_write_enable === 1'b0, mem_write_enable, 1'b0);
        check("rst_addr", mem_address === 12'h000, mem_address, 12'h000);
        check("rst_data", mem_data === 16'h0000, mem_data, 16'h0000);
        check("rst_ready", in_ready === 1'b0, in_ready, 1'b0);
        check_status();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (observed running, required finished)");
        $fatal(1, "timeout");
    end

    initial begin
        int id;
        reset = 1'b1; start = 1'b1; start_address = 12'habc; in_valid = 1'b1;
        ID = 7'h01; RegD = '0; RegA = '0; RegB = '0; Offset = '0; branch_condition = '0;
        exp_addr = '0; exp_count = '0; exp_error = 1'b0; exp_eid = '0;
        exp_busy = 1'b0; exp_done = 1'b0;

        // Reset overrides start; everything reads zero.
        @(posedge clock);
        @(negedge clock);
        check_all_zero();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check_all_zero();

        // Directed examples.
        do_start(12'h010);
        send('h01, 3, 2, 0, 5, 0);
        check("enc_0153", mem_data === 16'h0153, mem_data, 16'h0153);
        send('h28, 3, 2, 1, 0, 0);
        check("enc_5053", mem_data === 16'h5053, mem_data, 16'h5053);
        send('h49, 0, 0, 0, 'hfe, 0);
        check("enc_d0fe", mem_data === 16'hd0fe, mem_data, 16'hd0fe);
        send('h4b, 0, 0, 0, 0, 0);
        check("enc_e800", mem_data === 16'he800, mem_data, 16'he800);
        check("hlt_ready_low", in_ready === 1'b0, in_ready, 1'b0);
        idle_cycle();
        check("done_held", done === 1'b1, done, 1'b1);

        do_start(12'h100);
        send('h7a, 1, 2, 3, 4, 5);
        send('h7b, 1, 2, 3, 4, 5);
        send('h64, 1, 2, 3, 4, 5);
        check("enc_ffff", mem_data === 16'hffff, mem_data, 16'hffff);
        check("first_bad_id", error_id === 7'h7a, error_id, 7'h7a);
        idle_cycle();
        check("advanced_once", mem_address === 12'h101, mem_address, 12'h101);

        do_start(12'hfff);
        send('h48, 0, 0, 0, 3, 0);
        check("wrap_lo_data", mem_data === 16'hc003, mem_data, 16'hc003);
        send('h48, 0, 0, 0, 3, 0);
        check("wrap_addr", mem_address === 12'h000, mem_address, 12'h000);

        // Every encodable ID once with random fields.
        do_start(12'($urandom_range(0, 4095)));
        for (int i = 1; i <= 'h51; i++) begin
            id = (i == 'h51) ? 'h64 : i;
            if (id != 'h4b)
                send(id, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 4095), $urandom_range(0, 15));
        end

        // Random mix of valid/invalid IDs with idle gaps, ending on HLT.
        do_start(12'($urandom_range(0, 4095)));
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: id = $urandom_range(0, 127);
                1: id = 'h64;
                default: id = $urandom_range(1, 'h50);
            endcase
            if (id == 'h4b) id = 'h4a;
            send(id, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 4095), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        send('h4b, 0, 0, 0, 0, 0);
        idle_cycle();
        check("rand_done_ready", in_ready === 1'b0, in_ready, 1'b0);

        // Restart mid-session reloads address and clears the count.
        do_start(12'h300);
        send('h0c, 1, 1, 1, 1, 1);
        send('h27, 2, 2, 2, 2, 2);
        do_start(12'h055);
        check("restart_count", word_count === 13'h0000, word_count, 13'h0000);

        // Reset the cycle after a transfer suppresses its write.
        send('h02, 1, 1, 1, 1, 1);
        in_valid = 1'b1;
        ID = 7'h03;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_kills_write", mem_write_enable === 1'b0, mem_write_enable, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_addr = '0; exp_count = '0; exp_error = 1'b0; exp_eid = '0;
        exp_busy = 1'b0; exp_done = 1'b0;
        check_all_zero();
        @(negedge clock);
        check("post_reset_no_write", mem_write_enable === 1'b0, mem_write_enable, 1'b0);

        // Word counter saturates at all-ones.
        do_start(12'h000);
        for (int i = 0; i < 8195; i++)
            send('h01, $urandom_range(0, 15), $urandom_range(0, 15), 0,
                 $urandom_range(0, 4095), 0);
        check("count_saturated", word_count === 13'h1fff, word_count, 13'h1fff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
